// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encodings and instruction codes shared by the scan controller
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    // Written 32 bits wide and truncated to IR_WIDTH at the point of use
    localparam logic [31:0] EXTEST         = 32'h0000_0000;
    localparam logic [31:0] IDCODE         = 32'h0000_0001;
    localparam logic [31:0] SAMPLE_PRELOAD = 32'h0000_0002;
    localparam logic [31:0] BYPASS         = 32'hFFFF_FFFF;
    localparam logic [31:0] IR_CAPTURE     = 32'h0000_0001;

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state TAP state register and next-state logic driven by tms
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TLR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:    next_state = tms ? TLR    : RTI;
            RTI:    next_state = tms ? SEL_DR : RTI;
            SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR: next_state = tms ? EX1_DR : SH_DR;
            SH_DR:  next_state = tms ? EX1_DR : SH_DR;
            EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR: next_state = tms ? UPD_DR : SH_DR;
            UPD_DR: next_state = tms ? SEL_DR : RTI;
            SEL_IR: next_state = tms ? TLR    : CAP_IR;
            CAP_IR: next_state = tms ? EX1_IR : SH_IR;
            SH_IR:  next_state = tms ? EX1_IR : SH_IR;
            EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR: next_state = tms ? UPD_IR : SH_IR;
            UPD_IR: next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

endmodule

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - TAP controller: IR, bypass/IDCODE registers, BSR strobes and TDO mux
module tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                bsr_tdi,
    input  logic                bsr_tdo,
    output logic                bsr_shift_dr,
    output logic                bsr_capture_dr,
    output logic                bsr_update_dr,
    output logic                bsr_mode,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [3:0]          tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] IR_CAP_PAT = IR_WIDTH'(IR_CAPTURE);

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass;
    logic [31:0]         id_shift;
    logic                sel_bsr;
    logic                sel_id;
    logic                sel_bypass;
    logic                enter_tlr;

    tap_fsm u_tap_fsm (
        .clk   (clk),
        .reset (reset),
        .tms   (tms),
        .state (state)
    );

    // The only ways into TLR are holding tms high there or leaving SEL_IR with tms high
    assign enter_tlr = (state == TLR) || ((state == SEL_IR) && tms);

    always_comb begin
        sel_bsr    = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
        sel_id     = (ir == IR_IDCODE);
        sel_bypass = !sel_bsr && !sel_id;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
            bypass   <= 1'b0;
            id_shift <= '0;
        end else begin
            if (enter_tlr)           ir <= IR_IDCODE;
            else if (state == UPD_IR) ir <= ir_shift;

            if (state == CAP_IR)     ir_shift <= IR_CAP_PAT;
            else if (state == SH_IR) ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};

            if (state == CAP_DR) begin
                if (sel_bypass) bypass   <= 1'b0;
                if (sel_id)     id_shift <= IDCODE_VAL;
            end else if (state == SH_DR) begin
                if (sel_bypass) bypass   <= tdi;
                if (sel_id)     id_shift <= {tdi, id_shift[31:1]};
            end
        end
    end

    always_comb begin
        tdo_en         = (state == SH_DR) || (state == SH_IR);
        bsr_capture_dr = sel_bsr && (state == CAP_DR);
        bsr_shift_dr   = sel_bsr && (state == SH_DR);
        bsr_update_dr  = sel_bsr && (state == UPD_DR);
        bsr_mode       = (ir == IR_EXTEST);
        tdo            = 1'b0;
        if (state == SH_IR)      tdo = ir_shift[0];
        else if (state == SH_DR) tdo = sel_bsr ? bsr_tdo : (sel_id ? id_shift[0] : bypass);
    end

    assign bsr_tdi   = tdi;
    assign ir_out    = ir;
    assign tap_state = state;

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - randomized and directed checks of tap_controller against a reference model
module tb_tap_controller;

    localparam logic [31:0] ID_VAL = 32'h1000_0001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       bsr_tdo = 1'b0;
    logic       tdo, tdo_en, bsr_tdi, bsr_shift_dr, bsr_capture_dr, bsr_update_dr, bsr_mode;
    logic [3:0] ir_out;
    logic [3:0] tap_state;

    int checks = 0;
    int passes = 0;
    int cnt_cap = 0, cnt_sh = 0, cnt_upd = 0;

    tap_controller #(.IR_WIDTH(4), .IDCODE_VAL(ID_VAL)) dut (
        .clk            (clk),
        .reset          (reset),
        .tms            (tms),
        .tdi            (tdi),
        .tdo            (tdo),
        .tdo_en         (tdo_en),
        .bsr_tdi        (bsr_tdi),
        .bsr_tdo        (bsr_tdo),
        .bsr_shift_dr   (bsr_shift_dr),
        .bsr_capture_dr (bsr_capture_dr),
        .bsr_update_dr  (bsr_update_dr),
        .bsr_mode       (bsr_mode),
        .ir_out         (ir_out),
        .tap_state      (tap_state)
    );

    always #5 clk = ~clk;

    // Reference model: successor tables indexed by state, one per tms value
    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int          m_state = 0;
    int          m_ir = 1;
    int          m_irsh = 0;
    int          m_byp = 0;
    logic [31:0] m_id = '0;

    // 0 = boundary scan register, 1 = identification register, 2 = bypass
    function automatic int target(input int ir);
        if (ir == 0 || ir == 2) return 0;
        if (ir == 1) return 1;
        return 2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_ir = 1; m_irsh = 0; m_byp = 0; m_id = '0;
        end else begin
            int nxt;
            int tg;
            nxt = tms ? nx1[m_state] : nx0[m_state];
            tg  = target(m_ir);
            if (m_state == 10) m_irsh = 1;
            if (m_state == 11) m_irsh = (m_irsh >> 1) + (tdi ? 8 : 0);
            if (m_state == 3 && tg == 2) m_byp = 0;
            if (m_state == 3 && tg == 1) m_id = ID_VAL;
            if (m_state == 4 && tg == 2) m_byp = int'(tdi);
            if (m_state == 4 && tg == 1) m_id = {tdi, m_id[31:1]};
            if (nxt == 0) m_ir = 1;
            else if (m_state == 15) m_ir = m_irsh;
            m_state = nxt;
        end
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    endfunction

    always @(negedge clk) begin
        if ($time > 2) begin
            int  tg;
            bit  shifting;
            logic e_tdo;
            tg = target(m_ir);
            shifting = (m_state == 4) || (m_state == 11);
            e_tdo = 1'b0;
            if (m_state == 11) e_tdo = m_irsh[0];
            else if (m_state == 4) e_tdo = (tg == 0) ? bsr_tdo : (tg == 1) ? m_id[0] : m_byp[0];
            check("state", 32'(tap_state), 32'(m_state));
            check("ir_out", 32'(ir_out), 32'(m_ir));
            check("tdo_en", 32'(tdo_en), 32'(shifting));
            check("tdo", 32'(tdo), 32'(e_tdo));
            check("bsr_tdi", 32'(bsr_tdi), 32'(tdi));
            check("bsr_mode", 32'(bsr_mode), 32'(m_ir == 0));
            check("capture", 32'(bsr_capture_dr), 32'(tg == 0 && m_state == 3));
            check("shift", 32'(bsr_shift_dr), 32'(tg == 0 && m_state == 4));
            check("update", 32'(bsr_update_dr), 32'(tg == 0 && m_state == 8));
        end
    end

    // Drive one edge; returns at posedge+1 with strobe counters updated for the entered state
    task automatic step(input logic t, input logic d);
        tms = t; tdi = d; bsr_tdo = 1'($urandom);
        @(posedge clk); #1;
        cnt_cap += int'(bsr_capture_dr);
        cnt_sh  += int'(bsr_shift_dr);
        cnt_upd += int'(bsr_update_dr);
    endtask

    task automatic goto_rti();
        repeat (5) step(1'b1, 1'($urandom));
        step(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] v, output logic [3:0] seen);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            seen[i] = tdo;
            step(i == 3, v[i]);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic dr_start();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    logic [15:0] paths [16] = '{16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'h000A, 16'h000A,
                                16'h002A, 16'h001A, 16'h0006, 16'h0006, 16'h0006, 16'h0016, 16'h0016,
                                16'h0056, 16'h0036};
    int          plen  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    initial begin
        logic [31:0] word;
        logic [3:0]  seen;
        logic [3:0]  pat;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (10) step(1'($urandom), 1'($urandom));
        #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        check("rst_state", 32'(tap_state), 32'd0);
        check("rst_ir", 32'(ir_out), 32'h1);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_strobes", 32'(cnt_cap + cnt_sh + cnt_upd), 32'd0);

        step(1'b0, 1'b0);
        dr_start();
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        for (int i = 0; i < 32; i++) begin
            word[i] = tdo;
            step(i == 31, 1'b0);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("idcode_word", word, 32'h1000_0001);
        check("idcode_no_strobe", 32'(cnt_cap + cnt_sh + cnt_upd), 32'd0);

        scan_ir(4'b1111, seen);
        check("bypass_ir", 32'(ir_out), 32'hF);
        dr_start();
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            word[i] = tdo;
            step(i == 3, pat[i]);
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("bypass_tdo", 32'(word[3:0]), 32'hA);

        scan_ir(4'b0010, seen);
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        dr_start();
        for (int i = 0; i < 5; i++) step(i == 4, 1'($urandom));
        check("sp_mode", 32'(bsr_mode), 32'd0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("sp_capture", 32'(cnt_cap), 32'd1);
        check("sp_shift", 32'(cnt_sh), 32'd5);
        check("sp_update", 32'(cnt_upd), 32'd1);
        scan_ir(4'b0000, seen);
        check("extest_mode", 32'(bsr_mode), 32'd1);

        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        pat = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            seen[i] = tdo;
            step(i == 1 || i == 3, pat[i]);
            if (i == 1) begin
                step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b1);
            end
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("ir_capture_pat", 32'(seen), 32'h1);
        check("ir_detour", 32'(ir_out), 32'h3);
        dr_start();
        step(1'b0, 1'b1);
        check("ir3_as_bypass", 32'(tdo), 32'd1);

        for (int s = 0; s < 16; s++) begin
            logic [15:0] p;
            p = paths[s];
            goto_rti();
            step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
            for (int k = 0; k < plen[s]; k++) step(p[k], 1'($urandom));
            check("path_state", 32'(tap_state), 32'(s));
            repeat (5) step(1'b1, 1'($urandom));
            check("tlr_state", 32'(tap_state), 32'd0);
            check("tlr_ir", 32'(ir_out), 32'h1);
        end

        goto_rti();
        scan_ir(4'b0000, seen);
        dr_start();
        repeat (3) step(1'b0, 1'($urandom));
        cnt_upd = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_sh_mode", 32'(bsr_mode), 32'd0);
        check("rst_sh_state", 32'(tap_state), 32'd0);
        check("rst_sh_ir", 32'(ir_out), 32'h1);
        @(posedge clk); #1 reset = 1'b0;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("rst_sh_no_update", 32'(cnt_upd), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) < 40), 1'($urandom));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #3 reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
